// File: rtl/sort_pkg.sv
// Shared definitions for the sorting_box lanes and its feeders.
// Pad helper yields the maximum representable sample so padding sorts to the top lanes.
package sort_pkg;

  localparam int SORT_LANES  = 4;
  localparam int SORT_CNT_WD = 3;
  localparam int SORT_MAX_WD = 64;

  // The fill index doubles as the collector's state
  typedef enum logic [1:0] {
    FILL0 = 2'd0,
    FILL1 = 2'd1,
    FILL2 = 2'd2,
    FILL3 = 2'd3
  } fill_state_t;

  // Low (width) bits set; the sign bit is also cleared in signed mode
  function automatic logic [SORT_MAX_WD-1:0] sort_pad(input bit signed_mode, input int width);
    logic [SORT_MAX_WD-1:0] v;
    int                     ones;
    v    = '0;
    ones = signed_mode ? width - 1 : width;
    for (int i = 0; i < SORT_MAX_WD; i++) begin
      if (i < ones) v[i] = 1'b1;
    end
    return v;
  endfunction

endpackage

// File: rtl/sort_frame_collector_if.sv
// Sample-in / frame-out handshake bundle of the sort frame collector.
// Signal names are seen from the collector: i_* flow into it, o_* flow out.
interface sort_frame_collector_if #(
  parameter int DATA_WD = 8
);
  import sort_pkg::*;

  logic [DATA_WD-1:0]                 i_data;
  logic                               i_valid;
  logic                               i_flush;
  logic                               o_ready;
  logic [SORT_LANES-1:0][DATA_WD-1:0] o_frame;
  logic [SORT_CNT_WD-1:0]             o_frame_count;
  logic                               o_frame_valid;
  logic                               i_frame_ready;

  modport master (
    output i_data, i_valid, i_flush, i_frame_ready,
    input  o_ready, o_frame, o_frame_count, o_frame_valid
  );

  modport slave (
    input  i_data, i_valid, i_flush, i_frame_ready,
    output o_ready, o_frame, o_frame_count, o_frame_valid
  );

endinterface

// File: rtl/sort_frame_collector.sv
// Packs serial samples into 4-lane frames (lane 0 oldest); flush closes a partial frame with PAD lanes.
// Frame is valid the cycle after its closing accept; o_ready drops only for a 4th sample or flush while the output is stalled.
module sort_frame_collector
  import sort_pkg::*;
#(
  parameter int DATA_WD = 8,
  parameter bit SIGNED  = 1'b0
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  sort_frame_collector_if.slave bus
);

  localparam logic [DATA_WD-1:0] PAD = DATA_WD'(sort_pad(SIGNED, DATA_WD));

  fill_state_t                        r_idx;
  fill_state_t                        w_idx_nxt;
  logic [SORT_LANES-1:0][DATA_WD-1:0] r_fill;
  logic [SORT_LANES-1:0][DATA_WD-1:0] r_frame;
  logic [SORT_LANES-1:0][DATA_WD-1:0] w_frame_nxt;
  logic [SORT_CNT_WD-1:0]             r_count;
  logic [SORT_CNT_WD-1:0]             w_total;
  logic                               r_frame_vld;
  logic                               w_out_free;
  logic                               w_ready;
  logic                               w_accept;
  logic                               w_close;

  assign w_out_free = !r_frame_vld || bus.i_frame_ready;
  assign w_ready    = i_rst_n && (w_out_free || ((r_idx != FILL3) && !bus.i_flush));
  assign w_accept   = bus.i_valid && w_ready;
  assign w_total    = SORT_CNT_WD'(r_idx) + SORT_CNT_WD'(w_accept);
  // A close always has a free output slot: o_ready can only be high for it via w_out_free
  assign w_close    = w_ready && ((w_accept && (r_idx == FILL3)) ||
                                  (bus.i_flush && (w_total != '0)));

  always_comb begin
    w_frame_nxt = '0;
    for (int l = 0; l < SORT_LANES; l++) begin
      if (l < int'(r_idx)) begin
        w_frame_nxt[l] = r_fill[l];
      end else if ((l == int'(r_idx)) && w_accept) begin
        w_frame_nxt[l] = bus.i_data;
      end else begin
        w_frame_nxt[l] = PAD;
      end
    end
  end

  always_comb begin
    w_idx_nxt = r_idx;
    if (w_close) begin
      w_idx_nxt = FILL0;
    end else if (w_accept) begin
      w_idx_nxt = fill_state_t'(r_idx + 2'd1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_idx <= FILL0;
    end else begin
      r_idx <= w_idx_nxt;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_fill      <= '0;
      r_frame     <= '0;
      r_count     <= '0;
      r_frame_vld <= 1'b0;
    end else begin
      if (w_accept && !w_close) begin
        r_fill[r_idx] <= bus.i_data;
      end
      if (w_close) begin
        r_frame     <= w_frame_nxt;
        r_count     <= w_total;
        r_frame_vld <= 1'b1;
      end else if (r_frame_vld && bus.i_frame_ready) begin
        r_frame_vld <= 1'b0;
      end
    end
  end

  assign bus.o_ready       = w_ready;
  assign bus.o_frame       = r_frame;
  assign bus.o_frame_count = r_count;
  assign bus.o_frame_valid = r_frame_vld;

endmodule

// File: tb/tb_sort_frame_collector.sv
// Drives unsigned and signed collectors with identical stimulus and compares both against a queue-based frame model.
module tb_sort_frame_collector;
  import sort_pkg::*;

  localparam int DW = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sort_frame_collector_if #(.DATA_WD(DW)) bu ();
  sort_frame_collector_if #(.DATA_WD(DW)) bs ();

  sort_frame_collector #(.DATA_WD(DW), .SIGNED(1'b0)) u_dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bu)
  );

  sort_frame_collector #(.DATA_WD(DW), .SIGNED(1'b1)) u_dut_s (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bs)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: samples of the open frame, plus the presented output frame
  logic [7:0]  cur[$];
  bit          m_vld     = 1'b0;
  logic [31:0] m_cnt     = '0;
  logic [31:0] m_frame_u = '0;
  logic [31:0] m_frame_s = '0;
  bit          last_rdy  = 1'b1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc(input bit v, input logic [7:0] d, input bit f, input bit fr,
                     input bit rst, input string tag);
    bit exp_rdy;
    int n;
    rst_n            = !rst;
    bu.i_valid       = v;  bs.i_valid       = v;
    bu.i_data        = d;  bs.i_data        = d;
    bu.i_flush       = f;  bs.i_flush       = f;
    bu.i_frame_ready = fr; bs.i_frame_ready = fr;
    @(negedge clk);
    exp_rdy = !rst && (!m_vld || fr || ((cur.size() < 3) && !f));
    chk({tag, "_rdy"},    32'(bu.o_ready),       32'(exp_rdy));
    chk({tag, "_rdy_s"},  32'(bs.o_ready),       32'(exp_rdy));
    chk({tag, "_vld"},    32'(bu.o_frame_valid), 32'(m_vld));
    chk({tag, "_cnt"},    32'(bu.o_frame_count), m_cnt);
    chk({tag, "_frm"},    bu.o_frame,            m_frame_u);
    chk({tag, "_frm_s"},  bs.o_frame,            m_frame_s);
    last_rdy = exp_rdy;
    if (rst) begin
      cur.delete();
      m_vld = 1'b0; m_cnt = '0; m_frame_u = '0; m_frame_s = '0;
    end else if (exp_rdy) begin
      if (v) cur.push_back(d);
      n = cur.size();
      if ((n == 4) || (f && (n > 0))) begin
        for (int l = 0; l < 4; l++) begin
          m_frame_u[l*8 +: 8] = (l < n) ? cur[l] : 8'hFF;
          m_frame_s[l*8 +: 8] = (l < n) ? cur[l] : 8'h7F;
        end
        m_cnt = 32'(n);
        m_vld = 1'b1;
        cur.delete();
      end else if (m_vld && fr) begin
        m_vld = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit          rv, rf, rr, rfr;
    logic [7:0]  rd;

    cyc(0, 8'd0, 0, 1, 1, "rst0");
    cyc(0, 8'd0, 0, 1, 1, "rst1");

    // Full frame
    cyc(1, 8'd10, 0, 1, 0, "t1");
    cyc(1, 8'd20, 0, 1, 0, "t1");
    cyc(1, 8'd30, 0, 1, 0, "t1");
    cyc(1, 8'd40, 0, 1, 0, "t1");
    chk("t1_frame", bu.o_frame, {8'd40, 8'd30, 8'd20, 8'd10});
    chk("t1_count", 32'(bu.o_frame_count), 32'd4);
    chk("t1_valid", 32'(bu.o_frame_valid), 32'd1);
    cyc(0, 8'd0, 0, 1, 0, "t1i");
    chk("t1_onecyc", 32'(bu.o_frame_valid), 32'd0);

    // Backpressure
    for (int i = 1; i <= 7; i++) cyc(1, 8'(i), 0, 0, 0, "t2");
    cyc(1, 8'd8, 0, 0, 0, "t2s");
    chk("t2_stall",  32'(bu.o_ready), 32'd0);
    chk("t2_held",   bu.o_frame, {8'd4, 8'd3, 8'd2, 8'd1});
    cyc(1, 8'd8, 0, 1, 0, "t2r");
    chk("t2_frame2", bu.o_frame, {8'd8, 8'd7, 8'd6, 8'd5});
    chk("t2_count2", 32'(bu.o_frame_count), 32'd4);
    cyc(0, 8'd0, 0, 1, 0, "t2i");

    // Flush without sample
    cyc(1, 8'd5, 0, 1, 0, "t3");
    cyc(1, 8'd6, 0, 1, 0, "t3");
    cyc(0, 8'd0, 1, 1, 0, "t3f");
    chk("t3_frame_u", bu.o_frame, {8'hFF, 8'hFF, 8'd6, 8'd5});
    chk("t3_frame_s", bs.o_frame, {8'h7F, 8'h7F, 8'd6, 8'd5});
    chk("t3_count",   32'(bu.o_frame_count), 32'd2);

    // Flush with sample, then empty flush
    cyc(1, 8'd1, 0, 1, 0, "t4");
    cyc(1, 8'd2, 0, 1, 0, "t4");
    cyc(1, 8'd3, 1, 1, 0, "t4f");
    chk("t4_frame", bu.o_frame, {8'hFF, 8'd3, 8'd2, 8'd1});
    chk("t4_count", 32'(bu.o_frame_count), 32'd3);
    cyc(0, 8'd0, 1, 1, 0, "t4e");
    chk("t4_eflush_rdy", 32'(bu.o_ready), 32'd1);
    chk("t4_eflush_vld", 32'(bu.o_frame_valid), 32'd0);
    cyc(0, 8'd0, 0, 1, 0, "t4i");

    // Reset mid-frame
    cyc(1, 8'd50, 0, 1, 0, "t5");
    cyc(1, 8'd51, 0, 1, 0, "t5");
    cyc(0, 8'd0, 0, 1, 1, "t5r");
    chk("t5_rst_frame", bu.o_frame, 32'd0);
    chk("t5_rst_count", 32'(bu.o_frame_count), 32'd0);
    cyc(1, 8'd9, 0, 1, 0, "t5");
    cyc(1, 8'd8, 0, 1, 0, "t5");
    cyc(1, 8'd7, 0, 1, 0, "t5");
    cyc(1, 8'd6, 0, 1, 0, "t5");
    chk("t5_frame", bu.o_frame, {8'd6, 8'd7, 8'd8, 8'd9});
    cyc(0, 8'd0, 0, 1, 0, "t5i");

    // Back-to-back frames
    for (int i = 0; i < 8; i++) begin
      cyc(1, 8'(100 + i), 0, 1, 0, "t6");
      if (i == 3) chk("t6_first", bu.o_frame, {8'd103, 8'd102, 8'd101, 8'd100});
    end
    chk("t6_second", bu.o_frame, {8'd107, 8'd106, 8'd105, 8'd104});
    chk("t6_vld",    32'(bu.o_frame_valid), 32'd1);
    cyc(0, 8'd0, 0, 1, 0, "t6i");

    // Randomized traffic; held inputs are kept stable until accepted
    rv = 1'b0; rf = 1'b0; rd = '0;
    for (int i = 0; i < 3000; i++) begin
      rr  = ($urandom_range(0, 199) == 0);
      rfr = ($urandom_range(0, 9) < 7);
      if (last_rdy) begin
        rv = ($urandom_range(0, 3) != 0);
        rf = ($urandom_range(0, 7) == 0);
        rd = 8'($urandom);
      end
      cyc(rv, rd, rf, rfr, rr, "rnd");
      if (rr) last_rdy = 1'b1;
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
